// File: rtl/ber_checker.sv
// Receive-side BER checker: decimates the oversampled stream, hard-slices each symbol,
// self-synchronises a PRBS9 replica (x^9+x^5+1) and accumulates bit/error counts.
`timescale 1ns/1ps
module ber_checker #(
  parameter int NBT_IN   = 8,
  parameter int OVERSAMP = 4,
  parameter int NB_CNT   = 64,
  parameter int WIN_LEN  = 128,
  parameter int ERR_TH   = 16,
  parameter int INVERT   = 0
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic signed [NBT_IN-1:0]    i_sample,
  input  logic [$clog2(OVERSAMP)-1:0] i_phase,
  input  logic [$clog2(OVERSAMP)-1:0] i_sel_phase,
  input  logic                        i_enable,
  output logic                        o_bit,
  output logic                        o_bit_valid,
  output logic                        o_locked,
  output logic [NB_CNT-1:0]           o_bit_count,
  output logic [NB_CNT-1:0]           o_err_count
);

  localparam int WW = $clog2(WIN_LEN + 1);
  localparam logic [WW-1:0] WIN_END = WW'(WIN_LEN);
  localparam logic [WW-1:0] TH      = WW'(ERR_TH);
  localparam logic signed [NBT_IN-1:0] ZERO = '0;

  typedef enum logic {LOAD, CHECK} state_t;

  state_t          state;
  logic [8:0]      lfsr;
  logic [3:0]      load_cnt;
  logic [WW-1:0]   win_cnt;
  logic [WW-1:0]   win_err;

  logic            sym_en;
  logic            slice_bit;
  logic            pred;
  logic            err;
  logic [8:0]      load_next;
  logic [WW-1:0]   win_cnt_next;
  logic [WW-1:0]   win_err_next;

  assign sym_en       = i_enable && (i_phase == i_sel_phase);
  assign slice_bit    = (i_sample < ZERO) ^ (INVERT != 0);
  assign pred         = lfsr[8] ^ lfsr[4];
  assign err          = slice_bit ^ pred;
  assign load_next    = {lfsr[7:0], slice_bit};
  assign win_cnt_next = win_cnt + WW'(1);
  assign win_err_next = win_err + WW'(err);

  // The sliced bit is consumed by the FSM on the same edge it is registered,
  // so counters and o_locked move together with o_bit_valid.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= LOAD;
      lfsr        <= '0;
      load_cnt    <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_locked    <= 1'b0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else begin
      o_bit_valid <= sym_en;
      if (sym_en) begin
        o_bit <= slice_bit;
        if (state == LOAD) begin
          lfsr <= load_next;
          if (load_cnt != 4'd9)
            load_cnt <= load_cnt + 4'd1;
          // An all-zero register is the LFSR lock-up state, so keep loading.
          if ((load_cnt >= 4'd8) && (load_next != 9'd0)) begin
            state    <= CHECK;
            o_locked <= 1'b1;
          end
        end else begin
          lfsr <= {lfsr[7:0], pred};
          if (win_err_next > TH) begin
            state       <= LOAD;
            o_locked    <= 1'b0;
            load_cnt    <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
          end else begin
            if (o_bit_count != '1)
              o_bit_count <= o_bit_count + NB_CNT'(1);
            if (err && (o_err_count != '1))
              o_err_count <= o_err_count + NB_CNT'(1);
            if (win_cnt_next == WIN_END) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt_next;
              win_err <= win_err_next;
            end
          end
        end
      end
    end
  end

endmodule
